// File: rtl/exec_issue_controller.sv
// Issue/writeback sequencer for a single attached execution element.
// Launches the element on accept, waits for completion or timeout, then holds the writeback until taken.
module exec_issue_controller #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_dest,
  input  logic        issue_is_float,
  input  logic        flush,
  output logic        elem_reset,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_dest,
  output logic        wb_is_float,
  output logic [31:0] wb_data,
  output logic        timeout_err,
  output logic        busy
);

  // state | meaning
  // IDLE  | element parked, ready to accept an issue
  // RUN   | element running, counting cycles toward timeout
  // WB    | result held until the register file takes it
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] run_cnt;
  logic        accept, done, tout;

  assign issue_ready = (state == IDLE) & ~flush;
  assign accept      = issue_valid & issue_ready;
  // flush outranks completion, and completion outranks timeout
  assign done        = (state == RUN) & ~flush & elem_completed;
  assign tout        = (state == RUN) & ~flush & ~elem_completed & (run_cnt == TERM_CNT);

  assign elem_reset  = (state != RUN);
  assign wb_valid    = (state == WB);
  assign busy        = (state == RUN) | (state == WB);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (flush)     state_nxt = IDLE;
        else if (done) state_nxt = WB;
        else if (tout) state_nxt = IDLE;
      end
      WB: if (flush || wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_dest     <= '0;
      wb_is_float <= 1'b0;
      wb_data     <= '0;
      timeout_err <= 1'b0;
      run_cnt     <= '0;
    end else begin
      if (accept) begin
        wb_dest     <= issue_dest;
        wb_is_float <= issue_is_float;
        timeout_err <= 1'b0;
        run_cnt     <= '0;
      end else if (state == RUN && run_cnt != 16'hFFFF) begin
        run_cnt <= run_cnt + 16'd1;
      end
      if (done) wb_data <= elem_out;
      if (tout) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_issue_controller.sv
// Directed bench for exec_issue_controller with an operation-level reference model
// compared against the DUT on every falling edge.
module tb_exec_issue_controller;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_dest = '0;
  logic        issue_is_float = 1'b0;
  logic        flush = 1'b0;
  logic        elem_reset;
  logic        elem_completed = 1'b0;
  logic [31:0] elem_out = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_dest;
  logic        wb_is_float;
  logic [31:0] wb_data;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int failures = 0;

  exec_issue_controller #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest(issue_dest), .issue_is_float(issue_is_float), .flush(flush),
    .elem_reset(elem_reset), .elem_completed(elem_completed), .elem_out(elem_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_is_float(wb_is_float),
    .wb_data(wb_data), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Operation-level model: an operation is live from launch until it is written back or dropped.
  logic        m_live, m_has_result, m_tout, m_float;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  int          m_age;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_live <= 1'b0; m_has_result <= 1'b0; m_tout <= 1'b0; m_float <= 1'b0;
      m_dest <= '0; m_data <= '0; m_age <= 0;
    end else if (!m_live) begin
      if (issue_valid && !flush) begin
        m_live <= 1'b1; m_has_result <= 1'b0; m_age <= 0; m_tout <= 1'b0;
        m_dest <= issue_dest; m_float <= issue_is_float;
      end
    end else if (flush) begin
      m_live <= 1'b0; m_has_result <= 1'b0;
    end else if (m_has_result) begin
      if (wb_ready) begin m_live <= 1'b0; m_has_result <= 1'b0; end
    end else if (elem_completed) begin
      m_has_result <= 1'b1; m_data <= elem_out;
    end else if (m_age == TMO - 1) begin
      m_tout <= 1'b1; m_live <= 1'b0;
    end else begin
      m_age <= (m_age < 65535) ? m_age + 1 : m_age;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("m_issue_ready", {31'b0, issue_ready}, {31'b0, !m_live && !flush});
      chk("m_elem_reset",  {31'b0, elem_reset},  {31'b0, !(m_live && !m_has_result)});
      chk("m_wb_valid",    {31'b0, wb_valid},    {31'b0, m_live && m_has_result});
      chk("m_busy",        {31'b0, busy},        {31'b0, m_live});
      chk("m_timeout_err", {31'b0, timeout_err}, {31'b0, m_tout});
      chk("m_wb_dest",     {27'b0, wb_dest},     {27'b0, m_dest});
      chk("m_wb_is_float", {31'b0, wb_is_float}, {31'b0, m_float});
      chk("m_wb_data",     wb_data,              m_data);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [4:0] d, input logic f);
    issue_valid = 1'b1; issue_dest = d; issue_is_float = f;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb_cycles;
    #12 reset = 1'b0;
    chk("rst_elem_reset", {31'b0, elem_reset}, 32'd1);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
    chk("idle_issue_ready", {31'b0, issue_ready}, 32'd1);

    // single-cycle element, immediate writeback
    #1; wb_ready = 1'b1;
    launch(5'd7, 1'b1);
    elem_completed = 1'b1; elem_out = 32'h3F800000;
    tick();
    elem_completed = 1'b0;
    @(negedge clk);
    chk("lat_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lat_wb_dest", {27'b0, wb_dest}, 32'd7);
    chk("lat_wb_is_float", {31'b0, wb_is_float}, 32'd1);
    chk("lat_wb_data", wb_data, 32'h3F800000);
    tick();
    @(negedge clk);
    chk("lat_wb_done", {31'b0, wb_valid}, 32'd0);

    // writeback stalled by wb_ready=0 for five cycles
    #1; wb_ready = 1'b0;
    launch(5'd12, 1'b0);
    elem_completed = 1'b1; elem_out = 32'hDEADBEEF;
    tick();
    elem_completed = 1'b0;
    wb_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid) wb_cycles++;
      tick();
    end
    wb_ready = 1'b1;
    @(negedge clk);
    if (wb_valid) wb_cycles++;
    chk("stall_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("stall_wb_cycles", wb_cycles, 32'd6);

    // element never completes: timeout after four RUN cycles
    launch(5'd3, 1'b0);
    repeat (3) tick();
    chk("tmo_still_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("tmo_err_set", {31'b0, timeout_err}, 32'd1);
    chk("tmo_idle", {31'b0, busy}, 32'd0);
    chk("tmo_elem_reset", {31'b0, elem_reset}, 32'd1);
    launch(5'd4, 1'b1);
    chk("tmo_err_cleared", {31'b0, timeout_err}, 32'd0);
    elem_completed = 1'b1; elem_out = 32'h11;
    tick();
    elem_completed = 1'b0;
    tick();

    // completion on the fourth RUN edge beats the timeout
    launch(5'd9, 1'b0);
    repeat (3) tick();
    elem_completed = 1'b1; elem_out = 32'hA5A5A5A5;
    tick();
    elem_completed = 1'b0;
    chk("race_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("race_no_tmo", {31'b0, timeout_err}, 32'd0);
    chk("race_wb_data", wb_data, 32'hA5A5A5A5);
    tick();

    // flush during RUN
    launch(5'd20, 1'b1);
    flush = 1'b1; elem_completed = 1'b1; elem_out = 32'h55;
    tick();
    flush = 1'b0; elem_completed = 1'b0;
    chk("flush_run_busy", {31'b0, busy}, 32'd0);
    chk("flush_run_wbv", {31'b0, wb_valid}, 32'd0);
    chk("flush_run_erst", {31'b0, elem_reset}, 32'd1);

    // flush during WB with wb_ready high
    wb_ready = 1'b0;
    launch(5'd21, 1'b0);
    elem_completed = 1'b1; elem_out = 32'h66;
    tick();
    elem_completed = 1'b0; flush = 1'b1; wb_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_wb_wbv", {31'b0, wb_valid}, 32'd0);
    chk("flush_wb_busy", {31'b0, busy}, 32'd0);

    // flush in IDLE blocks acceptance
    flush = 1'b1; issue_valid = 1'b1; issue_dest = 5'd30;
    #1 chk("flush_idle_ready", {31'b0, issue_ready}, 32'd0);
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'b0, busy}, 32'd0);

    // asynchronous reset mid-RUN, then a clean operation
    launch(5'd15, 1'b1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_elem_reset", {31'b0, elem_reset}, 32'd1);
    chk("arst_wb_dest", {27'b0, wb_dest}, 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    issue_valid = 1'b1; issue_dest = 5'd5; issue_is_float = 1'b0;
    tick();
    issue_valid = 1'b0;
    chk("arst_relaunch", {31'b0, busy}, 32'd1);
    elem_completed = 1'b1; elem_out = 32'h12345678;
    tick();
    elem_completed = 1'b0;
    chk("arst_wb_data", wb_data, 32'h12345678);
    chk("arst_wb_dest5", {27'b0, wb_dest}, 32'd5);
    tick();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
